// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the single-port 2048x32 instruction BSRAM (CPU fetch + program loader).
// Define IMEM_ARB_RR_EN for alternating priority on contention in ARB; default is fixed loader priority.
module imem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              locked,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic              mem_reset,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                f_pend_q, f_pend_d;
  logic                l_pend_q, l_pend_d;
  logic [ADDR_W-1:0]   ad_q, ad_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
`ifdef IMEM_ARB_RR_EN
  logic                last_l_q, last_l_d;
`endif

  // Grant decision and lock state transitions
  always_comb begin
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;
    if (reset) begin
      state_d = ST_ARB;
    end else begin
      case (state_q)
        ST_ARB: begin
`ifdef IMEM_ARB_RR_EN
          if (f_req && l_req) begin
            f_gnt = last_l_q;
            l_gnt = ~last_l_q;
          end else begin
            f_gnt = f_req;
            l_gnt = l_req;
          end
`else
          l_gnt = l_req;
          f_gnt = f_req & ~l_req;
`endif
          state_d = l_lock ? ST_LOCK : ST_ARB;
        end
        ST_LOCK: begin
          l_gnt   = l_req;
          state_d = l_lock ? ST_LOCK : ST_ARB;
        end
        default: begin
          state_d = ST_ARB;
        end
      endcase
    end
  end

  // Memory drive; address and write data hold when idle so the BSRAM pins do not toggle
  always_comb begin
    mem_ce   = f_gnt | l_gnt;
    mem_wre  = l_gnt & l_we;
    ad_d     = ad_q;
    din_d    = din_q;
    f_pend_d = f_gnt;
    l_pend_d = l_gnt & ~l_we;
    if (l_gnt) begin
      ad_d = l_addr;
      if (l_we) begin
        din_d = l_wdata;
      end else begin
        din_d = din_q;
      end
    end else if (f_gnt) begin
      ad_d = f_addr;
    end else begin
      ad_d = ad_q;
    end
    mem_ad  = ad_d;
    mem_din = din_d;
    if (f_req && !f_gnt && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
`ifdef IMEM_ARB_RR_EN
    if (l_gnt) begin
      last_l_d = 1'b1;
    end else if (f_gnt) begin
      last_l_d = 1'b0;
    end else begin
      last_l_d = last_l_q;
    end
`endif
  end

  // State, pending read tags, held memory pins and stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_ARB;
      f_pend_q <= 1'b0;
      l_pend_q <= 1'b0;
      ad_q     <= {ADDR_W{1'b0}};
      din_q    <= {DATA_W{1'b0}};
      stall_q  <= {CNT_W{1'b0}};
`ifdef IMEM_ARB_RR_EN
      last_l_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      f_pend_q <= f_pend_d;
      l_pend_q <= l_pend_d;
      ad_q     <= ad_d;
      din_q    <= din_d;
      stall_q  <= stall_d;
`ifdef IMEM_ARB_RR_EN
      last_l_q <= last_l_d;
`endif
    end
  end

  // A read in flight when reset arrives is never reported
  assign f_rvalid  = f_pend_q & ~reset;
  assign l_rvalid  = l_pend_q & ~reset;
  assign f_rdata   = mem_dout;
  assign l_rdata   = mem_dout;
  assign locked    = (state_q == ST_LOCK);
  assign stall_cnt = stall_q;
  assign mem_oce   = 1'b1;
  assign mem_reset = reset;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural BSRAM model.
// A second instance with CNT_W=4 shares all inputs to observe counter saturation.
module tb_imem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_req, l_req, l_we, l_lock;
  logic [ADDR_W-1:0] f_addr, l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              f_gnt, f_rvalid, l_gnt, l_rvalid, locked;
  logic [DATA_W-1:0] f_rdata, l_rdata;
  logic [CNT_W-1:0]  stall_cnt;
  logic              mem_ce, mem_oce, mem_reset, mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din, mem_dout;

  logic              s_f_gnt, s_f_rvalid, s_l_gnt, s_l_rvalid, s_locked;
  logic [DATA_W-1:0] s_f_rdata, s_l_rdata, s_mem_din;
  logic [3:0]        s_stall_cnt;
  logic              s_mem_ce, s_mem_oce, s_mem_reset, s_mem_wre;
  logic [ADDR_W-1:0] s_mem_ad;

  logic [DATA_W-1:0] mem [0:2047];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_wre) mem[mem_ad] <= mem_din;
      else         mem_dout    <= mem[mem_ad];
    end
  end

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .locked(locked), .stall_cnt(stall_cnt),
    .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_reset(mem_reset), .mem_wre(mem_wre),
    .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(s_f_gnt), .f_rvalid(s_f_rvalid), .f_rdata(s_f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(s_l_gnt), .l_rvalid(s_l_rvalid), .l_rdata(s_l_rdata),
    .locked(s_locked), .stall_cnt(s_stall_cnt),
    .mem_ce(s_mem_ce), .mem_oce(s_mem_oce), .mem_reset(s_mem_reset), .mem_wre(s_mem_wre),
    .mem_ad(s_mem_ad), .mem_din(s_mem_din), .mem_dout(mem_dout)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[0] = 32'h00000013;
    mem[1] = 32'h00100093;
    mem[2] = 32'h00200113;
    mem_dout = 32'h0;
    reset = 1'b1; f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0;
    f_addr = 11'd0; l_addr = 11'd0; l_wdata = 32'h0;
    #2;
    // During reset: no grants, no memory access
    chk1("rst_f_gnt", f_gnt, 1'b0);
    chk1("rst_l_gnt", l_gnt, 1'b0);
    chk1("rst_mem_ce", mem_ce, 1'b0);
    chk1("rst_mem_reset", mem_reset, 1'b1);
    tick();
    reset = 1'b0; f_req = 1'b0; l_req = 1'b0;
    #2;
    chk1("rst_locked", locked, 1'b0);
    chk32("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk1("rst_f_rvalid", f_rvalid, 1'b0);
    chk1("rst_l_rvalid", l_rvalid, 1'b0);
    chk1("mem_oce", mem_oce, 1'b1);

    // Fetch only, pipelined reads of addresses 0,1,2
    f_req = 1'b1; f_addr = 11'd0; #2;
    chk1("fo_gnt0", f_gnt, 1'b1);
    chk32("fo_ad0", {21'd0, mem_ad}, 32'd0);
    chk1("fo_ce0", mem_ce, 1'b1);
    tick(); f_addr = 11'd1; #2;
    chk1("fo_gnt1", f_gnt, 1'b1);
    chk1("fo_rv1", f_rvalid, 1'b1);
    chk32("fo_rd1", f_rdata, 32'h00000013);
    tick(); f_addr = 11'd2; #2;
    chk1("fo_gnt2", f_gnt, 1'b1);
    chk1("fo_rv2", f_rvalid, 1'b1);
    chk32("fo_rd2", f_rdata, 32'h00100093);
    tick(); f_req = 1'b0; f_addr = 11'd7; #2;
    chk1("fo_rv3", f_rvalid, 1'b1);
    chk32("fo_rd3", f_rdata, 32'h00200113);
    chk1("fo_idle_gnt", f_gnt, 1'b0);
    chk1("fo_idle_ce", mem_ce, 1'b0);
    chk32("fo_ad_hold", {21'd0, mem_ad}, 32'd2);
    chk32("fo_stall", {16'd0, stall_cnt}, 32'd0);
    tick(); #2;
    chk1("fo_rv_off", f_rvalid, 1'b0);

    // Loader write then fetch read of the same word
    l_req = 1'b1; l_we = 1'b1; l_addr = 11'd5; l_wdata = 32'hDEADBEEF; #2;
    chk1("lw_gnt", l_gnt, 1'b1);
    chk1("lw_wre", mem_wre, 1'b1);
    chk32("lw_ad", {21'd0, mem_ad}, 32'd5);
    chk32("lw_din", mem_din, 32'hDEADBEEF);
    tick(); l_req = 1'b0; l_we = 1'b0; l_wdata = 32'h12345678; f_req = 1'b1; f_addr = 11'd5; #2;
    chk1("lw_no_rvalid", l_rvalid, 1'b0);
    chk1("lw_f_gnt", f_gnt, 1'b1);
    chk1("lw_f_wre", mem_wre, 1'b0);
    tick(); f_req = 1'b0; #2;
    chk1("lw_f_rv", f_rvalid, 1'b1);
    chk32("lw_f_rd", f_rdata, 32'hDEADBEEF);
    chk32("lw_din_hold", mem_din, 32'hDEADBEEF);

    // Loader read
    tick(); l_req = 1'b1; l_we = 1'b0; l_addr = 11'd1; #2;
    chk1("lr_gnt", l_gnt, 1'b1);
    chk1("lr_wre", mem_wre, 1'b0);
    tick(); l_req = 1'b0; #2;
    chk1("lr_rv", l_rvalid, 1'b1);
    chk1("lr_f_rv", f_rvalid, 1'b0);
    chk32("lr_rd", l_rdata, 32'h00100093);

    // Contention for 4 cycles: fetch addr 0, loader read addr 2
    tick(); f_req = 1'b1; f_addr = 11'd0; l_req = 1'b1; l_addr = 11'd2;
    for (int i = 0; i < 4; i++) begin
      #2;
`ifdef IMEM_ARB_RR_EN
      chk1("ct_f_gnt", f_gnt, (i % 2) == 0);
      chk1("ct_l_gnt", l_gnt, (i % 2) == 1);
      if (i > 0) begin
        chk1("ct_f_rv", f_rvalid, (i % 2) == 0 ? 1'b0 : 1'b1);
        chk1("ct_l_rv", l_rvalid, (i % 2) == 0 ? 1'b1 : 1'b0);
      end
`else
      chk1("ct_f_gnt", f_gnt, 1'b0);
      chk1("ct_l_gnt", l_gnt, 1'b1);
      if (i > 0) begin
        chk1("ct_l_rv", l_rvalid, 1'b1);
        chk32("ct_l_rd", l_rdata, 32'h00200113);
      end
`endif
      tick();
    end
    f_req = 1'b0; l_req = 1'b0; #2;
`ifdef IMEM_ARB_RR_EN
    exp_stall = 2;
`else
    exp_stall = 4;
`endif
    chk1("ct_last_l_rv", l_rvalid, 1'b1);
    chk32("ct_stall", {16'd0, stall_cnt}, exp_stall);

    // Lock: fetch granted in the entry cycle still gets its data
    tick(); l_lock = 1'b1; f_req = 1'b1; f_addr = 11'd0; #2;
    chk1("lk_entry_locked", locked, 1'b0);
    chk1("lk_entry_f_gnt", f_gnt, 1'b1);
    for (int k = 1; k < 10; k++) begin
      tick();
      l_req = (k == 5); l_we = 1'b0; l_addr = 11'd2;
      #2;
      chk1("lk_locked", locked, 1'b1);
      chk1("lk_f_gnt", f_gnt, 1'b0);
      chk32("lk_stall", {16'd0, stall_cnt}, exp_stall + k - 1);
      if (k == 1) begin
        chk1("lk_entry_rv", f_rvalid, 1'b1);
        chk32("lk_entry_rd", f_rdata, 32'h00000013);
      end
      if (k == 5) chk1("lk_l_gnt", l_gnt, 1'b1);
      if (k == 6) begin
        chk1("lk_l_rv", l_rvalid, 1'b1);
        chk32("lk_l_rd", l_rdata, 32'h00200113);
      end
    end
    tick(); l_lock = 1'b0; l_req = 1'b0; #2;
    chk1("ul_still_locked", locked, 1'b1);
    chk1("ul_f_gnt0", f_gnt, 1'b0);
    tick(); #2;
    chk1("ul_locked", locked, 1'b0);
    chk1("ul_f_gnt1", f_gnt, 1'b1);
    chk32("ul_stall", {16'd0, stall_cnt}, exp_stall + 10);

    // Reset while a fetch read is in flight
    f_addr = 11'd1;
    tick(); reset = 1'b1; f_req = 1'b0; #2;
    chk1("rm_rv_n1", f_rvalid, 1'b0);
    chk1("rm_gnt_n1", f_gnt, 1'b0);
    tick(); reset = 1'b0; #2;
    chk1("rm_rv_n2", f_rvalid, 1'b0);
    chk32("rm_stall", {16'd0, stall_cnt}, 32'd0);
    chk1("rm_locked", locked, 1'b0);

    // Saturation: hold lock and fetch for 20 cycles
    tick(); l_lock = 1'b1; f_req = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    l_lock = 1'b0; f_req = 1'b0; #2;
    chk32("sat_wide", {16'd0, stall_cnt}, 32'd19);
    chk32("sat_cnt4", {28'd0, s_stall_cnt}, 32'd15);
    tick(); tick(); #2;
    chk32("sat_hold", {28'd0, s_stall_cnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
